// File: rtl/pcie_os_pkg.sv
// Shared ordered-set definitions: OS type codes, scheduler state encoding and
// the default SKP insertion interval.
package pcie_os_pkg;

  localparam int unsigned OS_TYPE_W = 3;

  typedef logic [OS_TYPE_W-1:0] os_type_t;

  localparam os_type_t OS_TS1  = 3'b000;
  localparam os_type_t OS_TS2  = 3'b001;
  localparam os_type_t OS_SKP  = 3'b011;
  localparam os_type_t OS_IDLE = 3'b100;

  localparam int unsigned SKP_INTERVAL_DEFAULT = 1180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_FIN = 2'd2
  } sched_state_e;

  typedef enum logic {
    OWNER_LTSSM = 1'b0,
    OWNER_SKP   = 1'b1
  } os_owner_e;

endpackage

// File: rtl/os_tx_scheduler_if.sv
// LTSSM request/ack handshake and OS generator start/finish handshake.
// The scheduler takes the master view; the LTSSM/generator side takes the slave view.
interface os_tx_scheduler_if;
  import pcie_os_pkg::*;

  logic     LtssmReq;
  os_type_t LtssmOSType;
  logic     LtssmAck;
  logic     LtssmDone;
  logic     OSGeneratorStart;
  os_type_t OSType;
  logic     OSGeneratorBusy;
  logic     OSGeneratorFinish;

  modport master (
    input  LtssmReq,
    input  LtssmOSType,
    input  OSGeneratorBusy,
    input  OSGeneratorFinish,
    output LtssmAck,
    output LtssmDone,
    output OSGeneratorStart,
    output OSType
  );

  modport slave (
    output LtssmReq,
    output LtssmOSType,
    output OSGeneratorBusy,
    output OSGeneratorFinish,
    input  LtssmAck,
    input  LtssmDone,
    input  OSGeneratorStart,
    input  OSType
  );

endinterface

// File: rtl/skp_interval_timer.sv
// L0 SKP interval counter: raises skp_pending_o every SKP_INTERVAL cycles of L0,
// queues at most one SKP, and drops it when the granted SKP finishes.
module skp_interval_timer
  import pcie_os_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = SKP_INTERVAL_DEFAULT
) (
  input  logic Pclk,
  input  logic Reset,
  input  logic l0_active_i,
  input  logic clr_i,
  output logic skp_pending_o
);

  localparam int unsigned       CNT_W = $clog2(SKP_INTERVAL);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  // A wrap sets pending even if the previous SKP finishes in the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (!l0_active_i) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      pend_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr_i) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign skp_pending_o = pend_q;

endmodule

// File: rtl/os_tx_scheduler.sv
// Arbitrates the OS generator between LTSSM requests and periodic SKP insertion,
// counts completed LTSSM ordered sets, gates the TX FIFO and watchdogs the generator.
// Define OS_SKP_INSERT_EN to build the SKP interval timer and SKP owner path.
module os_tx_scheduler
  import pcie_os_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL    = SKP_INTERVAL_DEFAULT,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic                   Pclk,
  input  logic                   Reset,
  input  logic                   L0Active,
  os_tx_scheduler_if.master      bus,
  input  logic                   CountClear,
  output logic [COUNT_WIDTH-1:0] OSCount,
  output logic                   HoldFIFOData,
  output logic                   WatchdogErr
);

  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

  sched_state_e           state_q, state_d;
  os_owner_e              owner_q, owner_d;
  os_type_t               ostype_q, ostype_d;
  logic                   start_q, start_d;
  logic                   ack_q, ack_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   hold_q, hold_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   skp_pending;

`ifdef OS_SKP_INSERT_EN
  logic skp_clr_c;

  assign skp_clr_c = (state_q == ST_WAIT_FIN) && bus.OSGeneratorFinish &&
                     (owner_q == OWNER_SKP);

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_timer (
    .Pclk          (Pclk),
    .Reset         (Reset),
    .l0_active_i   (L0Active),
    .clr_i         (skp_clr_c),
    .skp_pending_o (skp_pending)
  );

  // FIFO held outside L0, while a SKP is queued, and while a SKP is in flight.
  assign hold_d = !L0Active || skp_pending ||
                  ((owner_q == OWNER_SKP) && (state_q != ST_IDLE));
`else
  logic unused_skp_interval;

  assign unused_skp_interval = ^SKP_INTERVAL;
  assign skp_pending         = 1'b0;
  assign hold_d              = !L0Active || (state_q != ST_IDLE);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ostype_d = ostype_q;
    start_d  = 1'b0;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    wdog_d   = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (!bus.OSGeneratorBusy) begin
          if (skp_pending) begin
            state_d  = ST_START;
            owner_d  = OWNER_SKP;
            ostype_d = OS_SKP;
            start_d  = 1'b1;
          end else if (bus.LtssmReq) begin
            state_d  = ST_START;
            owner_d  = OWNER_LTSSM;
            ostype_d = bus.LtssmOSType;
            start_d  = 1'b1;
            ack_d    = 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT_FIN;
        wdog_d  = WD_W'(1);
      end
      ST_WAIT_FIN: begin
        // wdog_q counts cycles since the start pulse; finish beats the timeout.
        if (bus.OSGeneratorFinish) begin
          state_d = ST_IDLE;
          if (owner_q == OWNER_LTSSM) begin
            done_d = 1'b1;
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end
        end else if (wdog_q == WD_W'(WATCHDOG_CYCLES)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (CountClear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_LTSSM;
      ostype_q <= '0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b1;
      count_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ostype_q <= ostype_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.OSGeneratorStart = start_q;
  assign bus.OSType           = ostype_q;
  assign bus.LtssmAck         = ack_q;
  assign bus.LtssmDone        = done_q;
  assign OSCount              = count_q;
  assign HoldFIFOData         = hold_q;
  assign WatchdogErr          = err_q;

endmodule
